// File: rtl/alu_mul_seq_pkg.sv
// Shared definitions for the alu and the shift-and-add multiply sequencer.
// Holds the alu funct encoding and the sequencer state type.
package alu_mul_seq_pkg;

    typedef enum logic [3:0] {
        SUM         = 4'd0,
        SHIFT_LEFT  = 4'd1,
        SUB         = 4'd2,
        LOAD        = 4'd3,
        XOR         = 4'd4,
        SHIFT_RIGHT = 4'd5,
        NOT         = 4'd6,
        AND         = 4'd7
    } alu_funct_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mul_state_t;

endpackage

// File: rtl/alu.sv
// Shared combinational alu used by execute and, while busy, by alu_mul_seq.
// Unused funct codes return zero.
module alu
    import alu_mul_seq_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic [3:0]       funct,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result
);

    localparam int SH_W = $clog2(WIDTH);

    logic [SH_W-1:0] shamt;

    assign shamt = b[SH_W-1:0];

    always_comb begin
        result = '0;
        case (alu_funct_t'(funct))
            SUM:         result = a + b;
            SHIFT_LEFT:  result = a << shamt;
            SUB:         result = a - b;
            LOAD:        result = b;
            XOR:         result = a ^ b;
            SHIFT_RIGHT: result = a >> shamt;
            NOT:         result = ~a;
            AND:         result = a & b;
            default:     result = '0;
        endcase
    end

endmodule

// File: rtl/alu_mul_seq.sv
// Shift-and-add multiplier sequencer that borrows the shared alu for its adds.
// ALU_MUL_EARLY_EXIT_EN: stop once no multiplier bits remain instead of a fixed WIDTH iterations.
//
// state | meaning
// IDLE  | waiting for an operand pair, req_ready high
// BUSY  | one partial-product add per cycle through the alu
// DONE  | product held on rsp_* until rsp_ready
module alu_mul_seq
    import alu_mul_seq_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_product,
    output logic             rsp_zero,
    output logic             busy,
    output logic [3:0]       alu_funct,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_result
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    mul_state_t       state;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [CNT_W-1:0] cnt;
    logic             last_iter;

`ifdef ALU_MUL_EARLY_EXIT_EN
    // The count limit is redundant here but keeps the iteration bound explicit.
    assign last_iter = ((mplier >> 1) == '0) || (cnt == CNT_W'(WIDTH - 1));
`else
    assign last_iter = (cnt == CNT_W'(WIDTH - 1));
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        mcand  <= req_a;
                        mplier <= req_b;
                        acc    <= '0;
                        cnt    <= '0;
                        state  <= BUSY;
                    end
                end
                BUSY: begin
                    acc    <= alu_result;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    if (last_iter) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign req_ready   = (state == IDLE);
    assign busy        = (state == BUSY);
    assign rsp_valid   = (state == DONE);
    assign rsp_product = acc;
    assign rsp_zero    = (acc == '0);

    // Outside BUSY the alu inputs are parked at zero so the shared alu stays quiet.
    always_comb begin
        alu_funct = SUM;
        alu_a     = '0;
        alu_b     = '0;
        if (state == BUSY) begin
            alu_a = acc;
            alu_b = mplier[0] ? mcand : '0;
        end
    end

endmodule

// File: tb/tb_alu_mul_seq.sv
// Scoreboard bench for alu_mul_seq driving the real alu.
// Expected products are queued at request time and compared when rsp_valid appears.
module tb_alu_mul_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [63:0] req_a;
    logic [63:0] req_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rsp_product;
    logic        rsp_zero;
    logic        busy;
    logic [3:0]  alu_funct;
    logic [63:0] alu_a;
    logic [63:0] alu_b;
    logic [63:0] alu_result;

    int checks = 0;
    int errors = 0;

    logic [63:0] exp_q[$];

    always #5 clk = ~clk;

    alu_mul_seq #(.WIDTH(64)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_product (rsp_product),
        .rsp_zero    (rsp_zero),
        .busy        (busy),
        .alu_funct   (alu_funct),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_result  (alu_result)
    );

    alu #(.WIDTH(64)) u_alu (
        .funct  (alu_funct),
        .a      (alu_a),
        .b      (alu_b),
        .result (alu_result)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got 0x%h want 0x%h", tag, obs, exp);
        end
    endtask

    function automatic int exp_lat(input logic [63:0] b);
`ifdef ALU_MUL_EARLY_EXIT_EN
        int msb;
        msb = 0;
        for (int i = 0; i < 64; i++) begin
            if (b[i]) msb = i;
        end
        return msb + 1;
`else
        return 64;
`endif
    endfunction

    // Quiet alu drive whenever the sequencer is not in BUSY.
    always @(negedge clk) begin
        if (!reset) begin
            check("alu_funct", {60'd0, alu_funct}, 64'd0);
            if (!busy) begin
                check("alu_a_quiet", alu_a, 64'd0);
                check("alu_b_quiet", alu_b, 64'd0);
            end
        end
    end

    task automatic run_op(input logic [63:0] a, input logic [63:0] b, input bit hold);
        int          n;
        logic [63:0] exp;
        rsp_ready = hold ? 1'b0 : 1'b1;
        @(negedge clk);
        check("req_ready_idle", {63'd0, req_ready}, 64'd1);
        req_valid = 1'b1;
        req_a     = a;
        req_b     = b;
        exp_q.push_back(a * b);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_a     = {$urandom, $urandom};
        req_b     = {$urandom, $urandom};
        n = 0;
        while (1) begin
            if (!rsp_valid) check("busy_during_op", {63'd0, busy}, 64'd1);
            @(posedge clk);
            #1;
            n++;
            if (rsp_valid) break;
            if (n > 200) begin
                check("rsp_timeout", 64'd0, 64'd1);
                break;
            end
        end
        check("latency", 64'(n), 64'(exp_lat(b)));
        check("busy_in_done", {63'd0, busy}, 64'd0);
        exp = exp_q.pop_front();
        check("product", rsp_product, exp);
        check("zero", {63'd0, rsp_zero}, {63'd0, (exp == 64'd0)});
        if (hold) begin
            for (int c = 0; c < 10; c++) begin
                @(negedge clk);
                check("bp_product", rsp_product, exp);
                check("bp_valid", {63'd0, rsp_valid}, 64'd1);
                check("bp_req_ready", {63'd0, req_ready}, 64'd0);
                if (c >= 3 && c <= 6) begin
                    req_valid = 1'b1;
                    req_a     = 64'd9;
                    req_b     = 64'd9;
                end else begin
                    req_valid = 1'b0;
                end
            end
            @(negedge clk);
            req_valid = 1'b0;
            rsp_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        check("rsp_drop", {63'd0, rsp_valid}, 64'd0);
        check("req_ready_back", {63'd0, req_ready}, 64'd1);
        if (hold) begin
            repeat (5) @(posedge clk);
            #1;
            check("ignored_req_idle", {62'd0, busy, rsp_valid}, 64'd0);
        end
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = 1'b0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst_req_ready", {63'd0, req_ready}, 64'd1);
        check("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_product", rsp_product, 64'd0);
        check("rst_zero", {63'd0, rsp_zero}, 64'd1);

        run_op(64'd12, 64'd25, 1'b0);
        run_op(-64'sd3, 64'd7, 1'b0);
        run_op(64'h7FFF_FFFF_FFFF_FFFF, 64'd3, 1'b0);
        run_op(64'd54, 64'd0, 1'b0);
        run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        run_op(64'd1, 64'h8000_0000_0000_0000, 1'b0);
        run_op(64'h1234_5678_9ABC_DEF0, 64'd1000, 1'b1);
        for (int i = 0; i < 4; i++) begin
            run_op({$urandom, $urandom}, {$urandom, $urandom}, 1'b0);
        end

        // Reset in the middle of BUSY discards the operation.
        @(negedge clk);
        req_valid = 1'b1;
        req_a     = 64'd11;
        req_b     = 64'hFFFF_FFFF_FFFF_FFFF;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("mid_busy", {63'd0, busy}, 64'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("mid_rst_ready", {63'd0, req_ready}, 64'd1);
        check("mid_rst_busy", {63'd0, busy}, 64'd0);
        check("mid_rst_valid", {63'd0, rsp_valid}, 64'd0);
        check("mid_rst_acc", rsp_product, 64'd0);
        begin
            int seen;
            seen = 0;
            for (int c = 0; c < 80; c++) begin
                @(posedge clk);
                #1;
                if (rsp_valid || busy) seen++;
            end
            check("mid_rst_no_rsp", 64'(seen), 64'd0);
        end
        run_op(64'd5, 64'd5, 1'b0);

        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
